float_recip_mul: RTL and testbench
==================================

FLOAT_RECIP_MUL -- requirements
Module: float_recip_mul

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port in_valid, input, 1, operand pair A/R valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-006 SHALL have port A, input, DATA_WIDTH, numerator (float).
REQ-007 SHALL have port R, input, DATA_WIDTH, reciprocal of denominator, produced by the floatRec stage.
REQ-008 SHALL have port out_valid, output, 1, Q holds a valid result.
REQ-009 SHALL have port out_ready, input, 1, consumer takes Q this cycle.
REQ-010 SHALL have port Q, output, DATA_WIDTH, quotient A*R (float).

Function
REQ-011 SHALL compute Q = A*R as a 3-stage pipeline:
- S1: unpack, sign XOR, biased exponent sum minus 127, special-case classify.
- S2: 24x24 mantissa product (hidden bit restored), 48-bit result.
- S3: normalize, round, pack.
REQ-012 SHALL accept a transfer when in_valid && in_ready, and retire one when out_valid && out_ready.
REQ-013 SHALL have latency exactly 3 cycles from accept to out_valid when no stall occurs; throughput 1 result per cycle.
REQ-014 SHALL stall all stages when out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
REQ-015 SHALL hold Q and out_valid stable while stalled; no result lost or duplicated.
REQ-016 SHALL let bubbles (invalid stages) collapse only by normal advance; no reordering.
REQ-017 SHALL accept a new input in the same cycle a stalled result is taken, because out_ready deasserts the stall combinationally.
REQ-018 SHALL normalize by shifting right 1 and incrementing the exponent when product bit 47 is set.
REQ-019 SHALL round to nearest, ties to even, using the guard bit and a sticky OR of the remaining bits.
REQ-020 SHALL renormalize on a rounding carry-out by incrementing the exponent.
REQ-021 SHALL treat any input with exponent field 0 as signed zero (denormals flushed).
REQ-022 SHALL output signed zero when the final exponent is <= 0 (underflow flush, no denormals).
REQ-023 SHALL output signed infinity (exp 0xFF, mantissa 0) when the final exponent is >= 255.
REQ-024 SHALL output 0x7FC00000 when either input is NaN, or for inf*0.
REQ-025 SHALL output signed infinity for inf*finite-nonzero, and signed zero for zero*finite.
REQ-026 SHALL give the result sign as sign(A) XOR sign(R) for all non-NaN results.

Reset
REQ-027 SHALL clear all stage valid bits while rst_n = 0 at a rising edge, giving out_valid=0, Q=0, in_ready=1 on the following cycle.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result emerges for any operation accepted before reset.
REQ-029 SHALL not accept a transfer on a cycle where rst_n = 0.

Verification
REQ-030 Basic: A=0x3F800000, R=0x40000000, out_ready=1, one beat -> Q=0x40000000 with out_valid exactly 3 cycles after accept.
REQ-031 Stream: back-to-back beats 0x40400000*0x3F000000, then 0xBF800000*0x40000000, then 0x7F000000*0x40000000 -> Q=0x3FC00000, 0xC0000000, 0x7F800000 on consecutive cycles.
REQ-032 Specials: 0x00800000*0x3F000000 -> 0x00000000; 0x7F800000*0x00000000 -> 0x7FC00000; 0x7FC00000*0x3F800000 -> 0x7FC00000.
REQ-033 Backpressure: 5 beats streamed, out_ready held 0 for 4 cycles after the first out_valid -> in_ready=0 during the stall, Q frozen, all 5 results delivered in order, none dropped.
REQ-034 Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 cycle -> out_valid stays 0 and no stale Q appears; a new beat then completes in 3 cycles.
REQ-035 Rounding: 0x3F800001*0x3F800001 -> 0x3F800002 (RNE); check against a $shortrealtobits reference model over 10k random pairs with denormals flushed.

Source files
------------

// File: rtl/float_recip_mul.sv
// float_recip_mul: pipelined IEEE-754 single-precision multiplier Q = A * R.
// R is the reciprocal of the denominator, so this stage finishes a division.
// The pipeline has three register stages:
//   S1 unpacks the operands, XORs the signs, adds the biased exponents and
//      classifies special operands.
//   S2 multiplies the 24-bit significands into a 48-bit product.
//   S3 normalizes, rounds to nearest-even, packs and registers Q.
// Denormal inputs are flushed to zero and results that would be denormal
// also flush to zero. Only DATA_WIDTH = 32 is supported.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   A/R carry an operand pair this cycle
//   in_ready   the block takes the operand pair this cycle
//   A, R       numerator and reciprocal of the denominator
//   out_valid  Q holds a result
//   out_ready  the consumer takes Q this cycle
//   Q          product A*R
module float_recip_mul #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] R,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Q
);

  // Operand class, resolved once in S1 and carried down the pipe.
  typedef enum logic [1:0] {
    ClsNorm,
    ClsZero,
    ClsInf,
    ClsNan
  } cls_e;

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  // The whole pipe moves in lock step. It freezes only when a result is
  // waiting and the consumer does not take it.
  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // S1: unpack, classify, sign and exponent
  // ---------------------------------------------------------------------------
  logic [7:0]  ea;
  logic [7:0]  er;
  logic        a_zero;
  logic        a_inf;
  logic        a_nan;
  logic        r_zero;
  logic        r_inf;
  logic        r_nan;

  logic        s1_valid_q;
  logic        s1_sign_d;
  logic        s1_sign_q;
  logic [9:0]  s1_exp_d;
  logic [9:0]  s1_exp_q;
  cls_e        s1_cls_d;
  cls_e        s1_cls_q;
  logic [23:0] s1_ma_d;
  logic [23:0] s1_ma_q;
  logic [23:0] s1_mr_d;
  logic [23:0] s1_mr_q;

  always_comb begin
    ea     = A[30:23];
    er     = R[30:23];
    // An exponent field of zero means zero or denormal; both are treated as zero.
    a_zero = (ea == 8'h00);
    a_inf  = (ea == 8'hFF) && (A[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (A[22:0] != 23'd0);
    r_zero = (er == 8'h00);
    r_inf  = (er == 8'hFF) && (R[22:0] == 23'd0);
    r_nan  = (er == 8'hFF) && (R[22:0] != 23'd0);

    s1_sign_d = A[31] ^ R[31];
    // Two's complement; the sum of normal exponents ranges from -125 to 381.
    s1_exp_d  = {2'b00, ea} + {2'b00, er} - 10'd127;
    s1_ma_d   = {1'b1, A[22:0]};
    s1_mr_d   = {1'b1, R[22:0]};

    if (a_nan || r_nan || (a_inf && r_zero) || (a_zero && r_inf)) begin
      s1_cls_d = ClsNan;
    end else if (a_inf || r_inf) begin
      s1_cls_d = ClsInf;
    end else if (a_zero || r_zero) begin
      s1_cls_d = ClsZero;
    end else begin
      s1_cls_d = ClsNorm;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: significand product
  // ---------------------------------------------------------------------------
  logic        s2_valid_q;
  logic        s2_sign_q;
  logic [9:0]  s2_exp_q;
  cls_e        s2_cls_q;
  logic [47:0] s2_prod_d;
  logic [47:0] s2_prod_q;

  assign s2_prod_d = 48'(s1_ma_q) * 48'(s1_mr_q);

  // ---------------------------------------------------------------------------
  // S3: normalize, round, pack
  // ---------------------------------------------------------------------------
  logic        norm;
  logic [22:0] mant_pre;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_rnd;
  logic [9:0]  exp_n;
  logic [9:0]  exp_r;
  logic [31:0] res;

  logic        s3_valid_q;
  logic [31:0] q_d;
  logic [31:0] q_q;

  always_comb begin
    // The product of two values in [1,2) lies in [1,4). If bit 47 is set,
    // the leading one is one place higher, so the exponent goes up by one.
    norm = s2_prod_q[47];
    if (norm) begin
      mant_pre = s2_prod_q[46:24];
      guard    = s2_prod_q[23];
      sticky   = |s2_prod_q[22:0];
    end else begin
      mant_pre = s2_prod_q[45:23];
      guard    = s2_prod_q[22];
      sticky   = |s2_prod_q[21:0];
    end
    exp_n    = s2_exp_q + {9'd0, norm};

    // Round to nearest. On an exact tie, round so that the LSB ends up even.
    round_up = guard & (sticky | mant_pre[0]);
    mant_rnd = {1'b0, mant_pre} + {23'd0, round_up};
    // A carry out leaves the fraction at zero (1.111..1 + ulp = 10.000..0),
    // so only the exponent needs adjusting.
    exp_r    = exp_n + {9'd0, mant_rnd[23]};

    unique case (s2_cls_q)
      ClsNan:  res = QNaN;
      ClsInf:  res = {s2_sign_q, 8'hFF, 23'd0};
      ClsZero: res = {s2_sign_q, 31'd0};
      default: begin
        if ($signed(exp_r) <= 10'sd0) begin
          res = {s2_sign_q, 31'd0};
        end else if ($signed(exp_r) >= 10'sd255) begin
          res = {s2_sign_q, 8'hFF, 23'd0};
        end else begin
          res = {s2_sign_q, exp_r[7:0], mant_rnd[22:0]};
        end
      end
    endcase

    // A bubble leaves the last result on Q instead of packing garbage.
    q_d = s2_valid_q ? res : q_q;
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= 10'd0;
      s1_cls_q   <= ClsZero;
      s1_ma_q    <= 24'd0;
      s1_mr_q    <= 24'd0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= 10'd0;
      s2_cls_q   <= ClsZero;
      s2_prod_q  <= 48'd0;
      s3_valid_q <= 1'b0;
      q_q        <= 32'd0;
    end else if (adv) begin
      // in_ready equals adv, so in_valid alone marks an accepted pair here.
      s1_valid_q <= in_valid;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_cls_q   <= s1_cls_d;
      s1_ma_q    <= s1_ma_d;
      s1_mr_q    <= s1_mr_d;
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_exp_q   <= s1_exp_q;
      s2_cls_q   <= s1_cls_q;
      s2_prod_q  <= s2_prod_d;
      s3_valid_q <= s2_valid_q;
      q_q        <= q_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign Q         = q_q;

endmodule

// File: tb/tb_float_recip_mul.sv
module tb_float_recip_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] r = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] q;

  logic [31:0] cur_exp = 32'd0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          lat_mode = 1'b1;
  bit          rand_rdy = 1'b0;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  float_recip_mul #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .R        (r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q        (q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: exact real-valued product, rounded to 24 significant bits
  // (nearest, ties to even) with an unbounded exponent, then range-clamped.
  function automatic real pow2(input int n);
    real v;
    v = 1.0;
    if (n >= 0) repeat (n) v = v * 2.0;
    else repeat (-n) v = v * 0.5;
    return v;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    int     ex, ey, e;
    bit     xz, yz, xi, yi, xn, yn;
    real    m, sc, fl;
    longint mi;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    m  = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(ex - 127) *
         (1.0 + real'(y[22:0]) / 8388608.0) * pow2(ey - 127);
    e  = ex + ey - 254;
    if (m >= pow2(e + 1)) e++;
    sc = m / pow2(e - 23);
    fl = $floor(sc);
    mi = longint'(fl);
    if ((sc - fl > 0.5) || ((sc - fl == 0.5) && mi[0])) mi++;
    if (mi == 64'd16777216) begin
      mi = 64'd8388608;
      e++;
    end
    if (e + 127 <= 0) return {s, 31'd0};
    if (e + 127 >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e + 127), mi[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'($urandom_range(0, 1) * 255);
      1: v[22:0] = 23'h7F_FFFF;
      2: v[30:23] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: samples at the falling edge, where everything it sees is what the
  // next rising edge will act on.
  logic [31:0] prev_q = 32'd0;
  bit          prev_stall = 1'b0;
  bit          presenting = 1'b0;
  item_t       it;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
      presenting = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_q", q, prev_q);
      end
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_output: got out_valid=1 Q=%h, want no result", q);
        end else begin
          if (!presenting) begin
            presenting = 1'b1;
            if (lat_mode) check("latency", 32'(cyc - sb[0].acc), 32'd3);
          end
          if (out_ready) begin
            it = sb.pop_front();
            check("q", q, it.exp);
            presenting = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{exp: cur_exp, acc: cyc});
      prev_stall = out_valid && !out_ready;
      prev_q     = q;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tr, input logic [31:0] te);
    int n;
    n        = 0;
    a        = ta;
    r        = tr;
    cur_exp  = te;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for 1000 cycles, want 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      idle(1);
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] ra, rb;

  initial begin
    // Reset with a pair offered: nothing may be accepted while rst_n is low.
    a        = 32'h3F80_0000;
    r        = 32'h3F80_0000;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_q", q, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic beat and back-to-back stream with fixed expectations.
    send(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    drain();
    send(32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000);
    send(32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
    send(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    // Specials and a rounding case.
    send(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
    send(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    send(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
    send(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    send(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    send(32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
    drain();

    // Backpressure: five beats, consumer stalls four cycles after first result.
    lat_mode = 1'b0;
    fork
      begin
        send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        send(32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000);
        send(32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
        send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          n++;
          @(negedge clk);
        end
        check("bp_first_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight; neither may emerge.
    lat_mode = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    send(32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(6);
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_q", q, 32'd0);
    @(posedge clk);
    #1;
    send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    drain();

    // Random pairs with a random consumer.
    lat_mode = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = rand_op();
      rb = rand_op();
      send(ra, rb, model(ra, rb));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
